// File: rtl/tpu_host_pkg.sv
// Shared definitions for the TPU host sequencer: pin instruction codes,
// sequencer states and result-buffer geometry.
package tpu_host_pkg;

    localparam logic [2:0] INSTR_NOP     = 3'b000;
    localparam logic [2:0] INSTR_LOAD    = 3'b001;
    localparam logic [2:0] INSTR_COMPUTE = 3'b010;
    localparam logic [2:0] INSTR_READ    = 3'b011;

    localparam int N_RESULTS = 4;
    localparam int RESULT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } state_t;

    // Widen a 3-bit instruction code to the 8-bit instruction pin bus.
    function automatic logic [7:0] instr_pins(input logic [2:0] code);
        return {5'b00000, code};
    endfunction

endpackage

// File: rtl/tpu_result_buffer.sv
// Four 16-bit result words, written one byte lane at a time as the TPU
// streams them out, read back by index during the drain phase.
module tpu_result_buffer
    import tpu_host_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_idx_i,
    input  logic                wr_hi_i,
    input  logic [7:0]          wr_byte_i,
    input  logic [1:0]          rd_idx_i,
    output logic [RESULT_W-1:0] rd_data_o
);

    logic [RESULT_W-1:0] mem_q [N_RESULTS];

    // Byte-lane write: low lane first, then high lane of the same word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_hi_i) begin
                mem_q[wr_idx_i][15:8] <= wr_byte_i;
            end else begin
                mem_q[wr_idx_i][7:0] <= wr_byte_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side master for the TPU pin protocol: streams eight operand bytes
// in as LOAD instructions, pulses COMPUTE, waits for done (with timeout),
// reads the eight result bytes back and hands out four 16-bit results.
module tpu_host_sequencer
    import tpu_host_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int N_OPERANDS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                res_valid,
    output logic [RESULT_W-1:0] res_data,
    output logic [1:0]          res_idx,
    input  logic                res_ready,
    output logic                busy,
    output logic                err_timeout,
    output logic [7:0]          tpu_data,
    output logic [7:0]          tpu_instr,
    input  logic [7:0]          tpu_result,
    input  logic                tpu_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = $clog2(N_OPERANDS + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         rd_q, rd_d;
    logic               rd_vld_q, rd_vld_d;
    logic [2:0]         cap_q, cap_d;
    logic [1:0]         idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               err_q, err_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         instr_q, instr_d;

    logic                accept;
    logic                buf_we;
    logic [RESULT_W-1:0] buf_rdata;

    assign accept = in_valid && in_ready_q;

    // State and pin registers; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            rd_q       <= '0;
            rd_vld_q   <= 1'b0;
            cap_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            instr_q    <= INSTR_NOP;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            rd_q       <= rd_d;
            rd_vld_q   <= rd_vld_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
            data_q     <= data_d;
            instr_q    <= instr_d;
        end
    end

    // Next-state and next-pin logic for the job sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        rd_d     = rd_q;
        cap_d    = cap_q;
        idx_d    = idx_q;
        err_d    = err_q;
        data_d   = data_q;
        instr_d  = INSTR_NOP;
        buf_we   = 1'b0;
        // A result byte appears on tpu_result the cycle after a READ was on the pins.
        rd_vld_d = (instr_q == INSTR_READ);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d = INSTR_LOAD;
                    data_d  = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    instr_d = INSTR_LOAD;
                    data_d  = in_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_OPERANDS - 1)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                instr_d = INSTR_COMPUTE;
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // While COMPUTE is still on the pins, done is stale from the previous job.
                if (tpu_done && (instr_q != INSTR_COMPUTE)) begin
                    instr_d = INSTR_READ;
                    rd_d    = 4'd1;
                    cap_d   = '0;
                    state_d = CAPTURE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CAPTURE: begin
                if (rd_q != 4'(2 * N_RESULTS)) begin
                    instr_d = INSTR_READ;
                    rd_d    = rd_q + 4'd1;
                end
                if (rd_vld_q) begin
                    buf_we = 1'b1;
                    cap_d  = cap_q + 3'd1;
                    if (cap_q == 3'(2 * N_RESULTS - 1)) begin
                        idx_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (res_ready) begin
                    if (idx_q == 2'(N_RESULTS - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    tpu_result_buffer u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_idx_i  (cap_q[2:1]),
        .wr_hi_i   (cap_q[0]),
        .wr_byte_i (tpu_result),
        .rd_idx_i  (idx_q),
        .rd_data_o (buf_rdata)
    );

    assign in_ready    = in_ready_q;
    assign res_valid   = (state_q == DRAIN);
    assign res_data    = res_valid ? buf_rdata : '0;
    assign res_idx     = idx_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;
    assign tpu_data    = data_q;
    assign tpu_instr   = instr_pins(instr_q);

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
- Host-side master for the TPU pin protocol: accepts an 8-byte operand stream, drives load and compute instructions onto the TPU data and instruction pins, waits for done, captures the streamed result bytes, and returns four 16-bit results over a valid/ready interface.
- Sits between a host or bus adapter and the TPU top-level pins. It is used on the test harness and companion FPGA side.

Parameters:
- TIMEOUT_CYC, 64, maximum cycles in WAIT_DONE before the error state.
- N_OPERANDS, 8, operand bytes per job (W0..W3, X0..X3); fixed by protocol.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand byte valid
- in_data  in  8  operand byte
- in_ready  out  1  sequencer accepts operand byte
- res_valid  out  1  result word valid
- res_data  out  16  result word C[res_idx]
- res_idx  out  2  result index (0=c00, 1=c01, 2=c10, 3=c11)
- res_ready  in  1  downstream accepts result
- busy  out  1  job in progress (any state except IDLE)
- err_timeout  out  1  sticky timeout flag, cleared by rst only
- tpu_data  out  8  drives TPU ui_in
- tpu_instr  out  8  drives TPU uio_in; bits [7:3] always 0
- tpu_result  in  8  from TPU uo_out
- tpu_done  in  1  from TPU uio_out[7]

Behaviour:
- Instruction codes (tpu_instr[2:0]):
  - NOP=000
  - LOAD=001: byte on tpu_data written at the auto-incremented address
  - COMPUTE=010: one-cycle start pulse
  - READ=011: advances output_sel
- Reset values: in_ready=0, res_valid=0, res_data=0, res_idx=0, busy=0, err_timeout=0, tpu_data=0, tpu_instr=NOP. State is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid, drive tpu_instr=LOAD and tpu_data=in_data registered. The LOAD instruction is presented on the pins 1 cycle after acceptance.
  - Set the byte counter to 1 and go to LOAD.
- LOAD:
  - in_ready=1. Each accepted byte produces one LOAD cycle. A cycle without in_valid drives NOP; the TPU address is held.
  - After byte 8 is accepted, go to START. in_ready=0 from that point.
- START: drive COMPUTE for exactly 1 cycle, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - Drive NOP.
  - On tpu_done=1, go to CAPTURE.
  - If the counter reaches TIMEOUT_CYC, set err_timeout and go to IDLE with result buffer invalid.
- CAPTURE:
  - For k=0..3, sample tpu_result in the cycle after READ is issued; tpu_result carries the low byte of C[k].
  - Then issue READ with the high-byte phase. 8 READ cycles total.
  - Capture into a 4x16 buffer: byte 2k goes to [7:0], byte 2k+1 goes to [15:8].
  - The TPU stream cannot stall, so capture never waits on res_ready.
- DRAIN:
  - Present buffer[res_idx] with res_valid=1. On res_valid&&res_ready, res_idx++.
  - After idx 3 transfers, res_valid=0, res_idx=0, return to IDLE.
  - res_data is stable while res_valid&&!res_ready.
- Accumulators are 16-bit in the TPU; there is no sign or width change here.
- Boundary conditions:
  - tpu_done already high at START: ignored until after the COMPUTE cycle.
  - in_valid during START/WAIT/CAPTURE/DRAIN: not accepted (in_ready=0).
  - rst mid-job: immediate return to reset values next edge. The TPU must be reset alongside it; no partial resume.
  - Timeout at exactly the same cycle as tpu_done: done wins, no error.

Decomposition:
- Package tpu_host_pkg:
  - instruction code constants (NOP/LOAD/COMPUTE/READ)
  - state enum {IDLE, LOAD, START, WAIT_DONE, CAPTURE, DRAIN}
  - N_RESULTS=4, RESULT_W=16
- One sub-module: tpu_result_buffer (4x16 regfile with byte-lane write and indexed read).

Test Plan:
- Operands W=[1,2,3,4], X=[5,6,7,8] with continuous in_valid, TPU model returns C=[19,22,43,50] -> 8 consecutive LOAD cycles with the exact byte order, one COMPUTE pulse, then res_data 19,22,43,50 with res_idx 0..3.
- Same job with in_valid gaps of 2 cycles between bytes -> NOP cycles between LOADs, identical results.
- Results 0x01FF, 0x8000, 0xFFFF, 0x0100 with res_ready held low 5 cycles -> res_data stable at 0x01FF, then all four in order with correct byte lanes.
- tpu_done never asserted -> err_timeout=1 after 64 WAIT cycles, state IDLE, in_ready=1, no res_valid.
- rst asserted during CAPTURE -> all outputs at reset values next cycle; a following full job completes correctly.
- tpu_done high throughout LOAD -> ignored; WAIT_DONE exits only after the COMPUTE pulse.
